cache_nway_ctrl: RTL and testbench
==================================

Name: cache_nway_ctrl

Overview:
- Parametrised N-way set-associative cache with tag/valid/true-LRU state and an integrated miss-fill state machine.
- Serves one 16-bit word request per cycle from the memory stage.
- On a miss it stalls the pipeline, fetches the whole block from main memory over a valid-qualified beat interface, allocates the block into the victim way, then completes the request.
- Replaces the fixed 2-way cache plus external fill control.

Parameters:
ADDR_WIDTH, 16, byte address width; bit 0 is ignored (word aligned)
WAYS, 4, associativity; power of two, 2 to 8
SETS, 64, sets per way; power of two
BLOCK_WORDS, 8, 16-bit words per block; power of two, 2 to 16

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_vld  input  1  memory-stage request valid
req_wr  input  1  1 = write word, 0 = read word
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  16  write data
rdata  output  16  read data; 0 when rdata_vld = 0
rdata_vld  output  1  read hit this cycle
stall  output  1  request not completed this cycle; pipeline holds
mem_rd_req  output  1  block fetch in progress
mem_addr  output  ADDR_WIDTH  byte address of the word currently being fetched
mem_rdata  input  16  memory return data
mem_rdata_vld  input  1  one fetched word on mem_rdata this cycle

Behaviour:
- Address split (LSB upward): bit0 ignored; offset = log2(BLOCK_WORDS) bits; index = log2(SETS) bits; tag = remaining bits.
- Per-line state: valid bit, tag, and a log2(WAYS)-bit age per way.
  - Ages within a set always form a permutation of 0..WAYS-1.
  - Age 0 = most recently used.
- Reset (async, rst_n = 0):
  - All valid bits cleared; age of way w = w in every set; FSM in IDLE.
  - Outputs: rdata = 0, rdata_vld = 0, stall = 0, mem_rd_req = 0, mem_addr = 0.
  - Data array contents are not reset.
- Lookup is combinational on req_addr against all ways of the indexed set.
  - hit = req_vld & one way valid with a matching tag.
  - At most one way may match; a multi-way match is a design error.
- IDLE, read hit: rdata = selected word, rdata_vld = 1, stall = 0, same cycle.
- IDLE, write hit: the word is written at the clock edge; stall = 0, rdata_vld = 0.
- LRU update on every hit with stall = 0:
  - The hit way takes age 0.
  - Ways whose age was below the hit way's old age increment by 1.
  - Other ways are unchanged.
- IDLE, miss:
  - stall = 1 combinationally in the same cycle.
  - Latch the address and select the victim: the lowest-numbered invalid way, otherwise the way with age WAYS-1.
  - Go to FILL.
- FILL:
  - stall = 1 and mem_rd_req = 1 for the whole state.
  - mem_addr = {latched tag, latched index, beat count, 0}.
  - Beat counter starts at 0.
  - Each cycle with mem_rdata_vld = 1 writes mem_rdata into the victim block at the word given by the beat count, then increments the count.
  - On the beat where count = BLOCK_WORDS-1: write the victim's tag and set valid = 1 at that edge, then go to DONE.
  - Beat count wraps to 0.
- DONE (one cycle):
  - stall = 1, mem_rd_req = 0; go to IDLE.
  - The pipeline still presents the same request, which now hits and completes in IDLE; this updates LRU and applies any write (write-allocate).
- Victim valid bit is cleared on FILL entry, so a partial fill never reads as a hit.
- Boundary conditions:
  - mem_rdata_vld outside FILL is ignored.
  - req_vld or req_addr changing during FILL/DONE is ignored; the fill always completes using the latched address.
  - req_vld = 0 in IDLE: no lookup effect, stall = 0.
  - Reset mid-fill aborts immediately: mem_rd_req drops asynchronously and the victim line stays invalid.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count [31:0] and miss_count [31:0], both reset to 0.
  - hit_count increments on each IDLE hit with stall = 0.
  - miss_count increments on each IDLE to FILL transition.
  - Both counters saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- After reset, read 16'h0402 → stall = 1 same cycle; next cycle mem_rd_req = 1, mem_addr = 16'h0400; 8 beats of data 16'h1000+i (gapped every other cycle) → DONE; next cycle rdata = 16'h1001, rdata_vld = 1, stall = 0.
- Write 16'hBEEF to 16'h0404 (hit), then read 16'h0404 → rdata = 16'hBEEF with no stall; mem_rd_req stays 0.
- Fill 4 tags in set 0 (addresses 16'h0000, 16'h0400, 16'h0800, 16'h0C00); hit 16'h0000; miss on 16'h1000 → victim is the way holding 16'h0400 (oldest); a later read of 16'h0000 hits and 16'h0400 misses.
- Write miss to 16'h2006 with data 16'h5A5A → full block fill, then write applied; read 16'h2006 = 16'h5A5A, other words equal the fetched data.
- Assert rst_n = 0 after beat 3 of a fill → mem_rd_req = 0 and stall = 0 immediately; after release, a read of the same address misses again.
- With CACHE_STATS_EN defined: 3 misses and 5 hits → miss_count = 3, hit_count = 5; without the macro, the same run produces identical rdata/stall traces.

Source files
------------

// File: rtl/cache_nway_ctrl.sv
// N-way set-associative word cache with true-LRU ages and an integrated block-fill FSM.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module cache_nway_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAYS        = 4,
    parameter int SETS        = 64,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_vld,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic [15:0]           rdata,
    output logic                  rdata_vld,
    output logic                  stall,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_rdata_vld
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - 1 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);
    localparam logic [WAY_W-1:0] OLDEST    = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [OFF_W-1:0]  r_beat;
    logic [TAG_W-1:0]  r_lat_tag;
    logic [IDX_W-1:0]  r_lat_idx;
    logic [WAY_W-1:0]  r_vic_way;

    logic              r_valid [WAYS][SETS];
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [WAY_W-1:0]  r_age   [WAYS][SETS];
    logic [15:0]       r_data  [WAYS][SETS][BLOCK_WORDS];

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [OFF_W-1:0]  w_off;
    logic [WAYS-1:0]   w_hit_vec;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_hit_age;
    logic [WAY_W-1:0]  w_victim;
    logic              w_hit;
    logic              w_miss;
    logic              w_last_beat;
    logic              w_unused;

    assign w_tag    = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_idx    = req_addr[OFF_W+1 +: IDX_W];
    assign w_off    = req_addr[1 +: OFF_W];
    assign w_unused = req_addr[0];

    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        w_victim  = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
            if (r_age[w][w_idx] == OLDEST) w_victim = WAY_W'(w);
        end
        // Descending scan so the lowest-numbered match / invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
            if (!r_valid[w][w_idx]) w_victim = WAY_W'(w);
        end
    end

    assign w_hit_age   = r_age[w_hit_way][w_idx];
    assign w_hit       = (r_state == S_IDLE) && req_vld && (|w_hit_vec);
    assign w_miss      = (r_state == S_IDLE) && req_vld && !(|w_hit_vec);
    assign w_last_beat = mem_rdata_vld && (r_beat == LAST_BEAT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_miss) w_next = S_FILL;
            S_FILL:  if (w_last_beat) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_lat_tag <= '0;
            r_lat_idx <= '0;
            r_vic_way <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_age[w][s]   <= WAY_W'(w);
                end
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == w_hit_way)
                                r_age[w][w_idx] <= '0;
                            else if (r_age[w][w_idx] < w_hit_age)
                                r_age[w][w_idx] <= r_age[w][w_idx] + 1'b1;
                        end
                    end else if (w_miss) begin
                        r_lat_tag                <= w_tag;
                        r_lat_idx                <= w_idx;
                        r_vic_way                <= w_victim;
                        r_beat                   <= '0;
                        r_valid[w_victim][w_idx] <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (mem_rdata_vld) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) r_valid[r_vic_way][r_lat_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data and tag arrays carry no reset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if (w_hit && req_wr)
            r_data[w_hit_way][w_idx][w_off] <= req_wdata;
        if ((r_state == S_FILL) && mem_rdata_vld) begin
            r_data[r_vic_way][r_lat_idx][r_beat] <= mem_rdata;
            if (w_last_beat) r_tag[r_vic_way][r_lat_idx] <= r_lat_tag;
        end
    end

    assign rdata_vld  = rst_n && w_hit && !req_wr;
    assign rdata      = rdata_vld ? r_data[w_hit_way][w_idx][w_off] : 16'h0000;
    assign stall      = rst_n && (w_miss || (r_state == S_FILL) || (r_state == S_DONE));
    assign mem_rd_req = (r_state == S_FILL);
    assign mem_addr   = (r_state == S_FILL) ? {r_lat_tag, r_lat_idx, r_beat, 1'b0} : '0;

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF))
                r_hit_count <= r_hit_count + 32'd1;
            if (w_miss && (r_miss_count != 32'hFFFF_FFFF))
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl: fills, hits, LRU victim choice, write-allocate, reset mid-fill.
module tb_cache_nway_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_vld = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] rdata;
    logic        rdata_vld;
    logic        stall;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_rdata_vld = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    cache_nway_ctrl #(
        .ADDR_WIDTH(16), .WAYS(4), .SETS(64), .BLOCK_WORDS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .rdata_vld(rdata_vld), .stall(stall),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rdata_vld(mem_rdata_vld)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_vld = 1'b0;
        req_wr = 1'b0;
        mem_rdata_vld = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_rdata_vld", rdata_vld, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_rd_req", mem_rd_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_miss(input logic [15:0] addr, input logic wr, input logic [15:0] wdata);
        req_vld = 1'b1;
        req_wr = wr;
        req_addr = addr;
        req_wdata = wdata;
        #1;
        chk("miss_stall", stall, 1);
        chk("miss_no_memreq", mem_rd_req, 0);
        step();
    endtask

    task automatic run_fill(input logic [15:0] addr, input logic [15:0] dbase, input bit gapped,
                            input bit disturb, input logic wr, input logic [15:0] wdata);
        logic [15:0] blk;
        blk = addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            if (disturb) begin
                req_vld = 1'b0;
                req_addr = 16'hFFFE;
            end
            if (gapped) begin
                mem_rdata_vld = 1'b0;
                mem_rdata = 16'h0BAD;
                #1;
                chk("fill_gap_req", mem_rd_req, 1);
                chk("fill_gap_addr", mem_addr, blk | 16'(i * 2));
                step();
            end
            mem_rdata_vld = 1'b1;
            mem_rdata = dbase + 16'(i);
            #1;
            chk("fill_addr", mem_addr, blk | 16'(i * 2));
            chk("fill_stall", stall, 1);
            step();
        end
        mem_rdata_vld = 1'b0;
        req_vld = 1'b1;
        req_addr = addr;
        req_wr = wr;
        req_wdata = wdata;
        #1;
        chk("done_memreq", mem_rd_req, 0);
        chk("done_stall", stall, 1);
        step();
    endtask

    task automatic read_hit(input logic [15:0] addr, input logic [15:0] exp);
        req_vld = 1'b1;
        req_wr = 1'b0;
        req_addr = addr;
        #1;
        chk("rd_stall", stall, 0);
        chk("rd_vld", rdata_vld, 1);
        chk("rd_data", rdata, exp);
        chk("rd_memreq", mem_rd_req, 0);
        step();
    endtask

    task automatic write_hit(input logic [15:0] addr, input logic [15:0] data);
        req_vld = 1'b1;
        req_wr = 1'b1;
        req_addr = addr;
        req_wdata = data;
        #1;
        chk("wr_stall", stall, 0);
        chk("wr_rdata_vld", rdata_vld, 0);
        step();
        req_wr = 1'b0;
    endtask

    task automatic fill_block(input logic [15:0] addr, input logic [15:0] dbase);
        start_miss(addr, 1'b0, 16'h0);
        run_fill(addr, dbase, 1'b0, 1'b0, 1'b0, 16'h0);
        read_hit(addr, dbase + 16'((addr >> 1) & 16'h7));
    endtask

    initial begin
        do_reset();

        // Gapped fill of block 0x0400, completing read of word 1
        start_miss(16'h0402, 1'b0, 16'h0);
        run_fill(16'h0402, 16'h1000, 1'b1, 1'b0, 1'b0, 16'h0);
        read_hit(16'h0402, 16'h1001);

        // Write hit; return data outside FILL must be ignored
        mem_rdata_vld = 1'b1;
        mem_rdata = 16'hDEAD;
        write_hit(16'h0404, 16'hBEEF);
        read_hit(16'h0404, 16'hBEEF);
        mem_rdata_vld = 1'b0;
        read_hit(16'h0400, 16'h1000);
        read_hit(16'h040E, 16'h1007);

        // LRU victim selection in set 0
        do_reset();
        fill_block(16'h0000, 16'h2000);
        fill_block(16'h0400, 16'h2100);
        fill_block(16'h0800, 16'h2200);
        fill_block(16'h0C00, 16'h2300);
        read_hit(16'h0000, 16'h2000);
        fill_block(16'h1000, 16'h2400);
        read_hit(16'h0000, 16'h2000);
        read_hit(16'h0802, 16'h2201);
        read_hit(16'h0C04, 16'h2302);
        read_hit(16'h1006, 16'h2403);
        req_addr = 16'h0400;
        #1;
        chk("evicted_miss", stall, 1);
        req_vld = 1'b0;
        #1;
        chk("idle_novld_stall", stall, 0);
        chk("idle_novld_rvld", rdata_vld, 0);
        step();

        // Write miss with write-allocate; request lines disturbed during fill
        do_reset();
        start_miss(16'h2006, 1'b1, 16'h5A5A);
        run_fill(16'h2006, 16'h3000, 1'b0, 1'b1, 1'b1, 16'h5A5A);
        req_vld = 1'b1;
        req_wr = 1'b1;
        req_addr = 16'h2006;
        req_wdata = 16'h5A5A;
        #1;
        chk("wa_stall", stall, 0);
        chk("wa_rdata_vld", rdata_vld, 0);
        step();
        read_hit(16'h2006, 16'h5A5A);
        read_hit(16'h2000, 16'h3000);
        read_hit(16'h2002, 16'h3001);
        read_hit(16'h200E, 16'h3007);

        // Reset in the middle of a fill
        do_reset();
        start_miss(16'h0802, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            mem_rdata_vld = 1'b1;
            mem_rdata = 16'h4000 + 16'(i);
            step();
        end
        rst_n = 1'b0;
        mem_rdata_vld = 1'b0;
        #1;
        chk("midrst_memreq", mem_rd_req, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after_rst_miss", stall, 1);
        req_vld = 1'b0;
        step();

        // Three misses then two further hits
        do_reset();
        fill_block(16'h0000, 16'h5000);
        fill_block(16'h0400, 16'h5100);
        fill_block(16'h0800, 16'h5200);
        read_hit(16'h0000, 16'h5000);
        read_hit(16'h0400, 16'h5100);
        req_vld = 1'b0;
        #1;
`ifdef CACHE_STATS_EN
        chk("miss_count", miss_count, 3);
        chk("hit_count", hit_count, 5);
`endif
        chk("final_stall", stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
